// File: rtl/bullet_scheduler.sv
// Player bullet pool: turns fire presses into spawns, moves bullets up each game tick,
// retires them at the top of the screen or on a hit, and flags pixels covered by a bullet.
module bullet_scheduler #(
  parameter int NUM_SLOTS = 4,
  parameter int SPEED     = 4,
  parameter int COOLDOWN  = 8,
  parameter int TOP_Y     = 35,
  parameter int BULLET_H  = 6,
  parameter int BULLET_HW = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fire,
  input  logic                         tick,
  input  logic [9:0]                   tank_x,
  input  logic [9:0]                   tank_y,
  input  logic                         hit_valid,
  input  logic [$clog2(NUM_SLOTS)-1:0] hit_slot,
  input  logic [9:0]                   hCount,
  input  logic [9:0]                   vCount,
  output logic                         bullet_pixel,
  output logic [NUM_SLOTS-1:0]         active_mask,
  output logic [10*NUM_SLOTS-1:0]      slot_x,
  output logic [10*NUM_SLOTS-1:0]      slot_y,
  output logic                         shot_fired,
  output logic                         fire_dropped
);

  localparam int SW = $clog2(NUM_SLOTS);
  localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [10:0] SPAWN_MIN_Y = 11'(TOP_Y + BULLET_H);
  localparam logic [10:0] RETIRE_Y    = 11'(TOP_Y + SPEED);

  logic [NUM_SLOTS-1:0] mask;
  logic [9:0]           x_q [NUM_SLOTS];
  logic [9:0]           y_q [NUM_SLOTS];
  logic [CW-1:0]        cooldown;
  logic                 pending;
  logic                 fire_d;

  logic                 fire_edge;
  logic                 want;
  logic                 free_found;
  logic [SW-1:0]        free_idx;
  logic                 can_alloc;
  logic [NUM_SLOTS-1:0] hit_vec;
  logic                 pix_any;

  // A fire edge arriving on the tick itself counts toward that tick.
  always_comb begin
    fire_edge = fire & ~fire_d;
    want      = pending | fire_edge;

    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!mask[i]) begin
        free_found = 1'b1;
        free_idx   = SW'(i);
      end
    end

    can_alloc = tick && want && (cooldown == '0) && free_found &&
                ({1'b0, tank_y} >= SPAWN_MIN_Y);

    hit_vec = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (hit_valid && (SW'(i) == hit_slot)) hit_vec[i] = 1'b1;
    end
  end

  // NOTE: slot coordinates are visible outputs, so the arrays are reset explicitly
  // rather than left as don't-care storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask         <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
      cooldown     <= '0;
      pending      <= 1'b0;
      fire_d       <= 1'b0;
      shot_fired   <= 1'b0;
      fire_dropped <= 1'b0;
    end else begin
      fire_d       <= fire;
      shot_fired   <= 1'b0;
      fire_dropped <= 1'b0;

      // A hit beats movement; retire instead of moving past the top line.
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (hit_vec[i]) begin
          mask[i] <= 1'b0;
        end else if (tick && mask[i]) begin
          if ({1'b0, y_q[i]} < RETIRE_Y) mask[i] <= 1'b0;
          else                          y_q[i]  <= y_q[i] - 10'(SPEED);
        end
      end

      if (tick) begin
        pending <= 1'b0;
        if (can_alloc) begin
          // Only slots free before this edge are chosen, so a same-clk hit cannot be reused.
          mask[free_idx] <= 1'b1;
          x_q[free_idx]  <= tank_x;
          y_q[free_idx]  <= tank_y - 10'(BULLET_H);
          cooldown       <= CW'(COOLDOWN);
          shot_fired     <= 1'b1;
        end else begin
          if (want)             fire_dropped <= 1'b1;
          if (cooldown != '0)   cooldown     <= cooldown - 1'b1;
        end
      end else if (fire_edge) begin
        pending <= 1'b1;
      end
    end
  end

  // Compares are 11 bits wide so x - BULLET_HW cannot wrap near column 0.
  always_comb begin
    pix_any = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (mask[i] &&
          ({1'b0, hCount} + 11'(BULLET_HW) >= {1'b0, x_q[i]}) &&
          ({1'b0, hCount} <= {1'b0, x_q[i]} + 11'(BULLET_HW)) &&
          ({1'b0, vCount} >= {1'b0, y_q[i]}) &&
          ({1'b0, vCount} <= {1'b0, y_q[i]} + 11'(BULLET_H - 1)))
        pix_any = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bullet_pixel <= 1'b0;
    else      bullet_pixel <= pix_any;
  end

  always_comb begin
    slot_x = '0;
    slot_y = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_x[10*i +: 10] = x_q[i];
      slot_y[10*i +: 10] = y_q[i];
    end
  end

  assign active_mask = mask;

endmodule

// File: tb/tb_bullet_scheduler.sv
// Self-checking bench for bullet_scheduler: default instance plus a zero-cooldown instance.
module tb_bullet_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fire = 1'b0;
  logic       tick = 1'b0;
  logic [9:0] tank_x = '0;
  logic [9:0] tank_y = '0;
  logic       hit_valid = 1'b0;
  logic [1:0] hit_slot = '0;
  logic [9:0] hCount = '0;
  logic [9:0] vCount = '0;

  logic        pix_a, shot_a, drop_a;
  logic [3:0]  mask_a;
  logic [39:0] sx_a, sy_a;
  logic        pix_b, shot_b, drop_b;
  logic [3:0]  mask_b;
  logic [39:0] sx_b, sy_b;

  int total = 0;
  int bad   = 0;

  bullet_scheduler dut (
    .clk(clk), .rst(rst), .fire(fire), .tick(tick), .tank_x(tank_x), .tank_y(tank_y),
    .hit_valid(hit_valid), .hit_slot(hit_slot), .hCount(hCount), .vCount(vCount),
    .bullet_pixel(pix_a), .active_mask(mask_a), .slot_x(sx_a), .slot_y(sy_a),
    .shot_fired(shot_a), .fire_dropped(drop_a)
  );

  bullet_scheduler #(.COOLDOWN(0)) dut0 (
    .clk(clk), .rst(rst), .fire(fire), .tick(tick), .tank_x(tank_x), .tank_y(tank_y),
    .hit_valid(hit_valid), .hit_slot(hit_slot), .hCount(hCount), .vCount(vCount),
    .bullet_pixel(pix_b), .active_mask(mask_b), .slot_x(sx_b), .slot_y(sy_b),
    .shot_fired(shot_b), .fire_dropped(drop_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] h;
    logic [9:0] v;
    logic       exp;
  } pix_vec_t;

  pix_vec_t pix_tab[8];
  logic     exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    fire = 1'b0; tick = 1'b0; hit_valid = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
  endtask

  // Rising fire edge on one clk, tick on the next.
  task automatic fire_then_tick();
    fire = 1'b1;
    cyc();
    fire = 1'b0;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  initial begin
    pix_tab[0] = '{10'd451, 10'd500, 1'b1};
    pix_tab[1] = '{10'd452, 10'd500, 1'b0};
    pix_tab[2] = '{10'd449, 10'd497, 1'b1};
    pix_tab[3] = '{10'd448, 10'd497, 1'b0};
    pix_tab[4] = '{10'd450, 10'd502, 1'b1};
    pix_tab[5] = '{10'd450, 10'd503, 1'b0};
    pix_tab[6] = '{10'd450, 10'd496, 1'b0};
    pix_tab[7] = '{10'd450, 10'd499, 1'b1};

    // Reset state
    #1;
    check("reset_mask", 32'(mask_a), 0);
    check("reset_pixel", 32'(pix_a), 0);
    check("reset_shot", 32'(shot_a), 0);
    check("reset_slot_y", sy_a[31:0], 0);
    cyc();
    rst = 1'b1;
    cyc();

    // First spawn at the tank position
    tank_x = 10'd450;
    tank_y = 10'd515;
    fire_then_tick();
    check("spawn_shot", 32'(shot_a), 1);
    check("spawn_mask", 32'(mask_a), 32'h1);
    check("spawn_x", 32'(sx_a[9:0]), 450);
    check("spawn_y", 32'(sy_a[9:0]), 509);
    cyc();
    check("shot_pulse_end", 32'(shot_a), 0);

    // Three moves, then pixel table through the scoreboard
    tick = 1'b1;
    repeat (3) cyc();
    tick = 1'b0;
    check("moved_y", 32'(sy_a[9:0]), 497);
    foreach (pix_tab[i]) begin
      hCount = pix_tab[i].h;
      vCount = pix_tab[i].v;
      exp_q.push_back(pix_tab[i].exp);
      cyc();
      check($sformatf("pixel_%0d_%0d", pix_tab[i].h, pix_tab[i].v), 32'(pix_a), 32'(exp_q.pop_front()));
    end

    // Fire before each of 10 ticks: cooldown allows only ticks 1 and 10
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      exp_q.push_back((k == 1) || (k == 10));
      fire_then_tick();
      begin
        logic e;
        e = exp_q.pop_front();
        check($sformatf("cd_shot_%0d", k), 32'(shot_a), 32'(e));
        check($sformatf("cd_drop_%0d", k), 32'(drop_a), 32'(!e));
      end
    end
    check("cd_mask", 32'(mask_a), 32'h3);

    // Spawn blocked too close to top, then retire boundary
    do_reset();
    tank_y = 10'd40;
    fire_then_tick();
    check("low_tank_drop", 32'(drop_a), 1);
    check("low_tank_mask", 32'(mask_a), 0);
    tank_y = 10'd45;
    fire_then_tick();
    check("edge_spawn_y", 32'(sy_a[9:0]), 39);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    check("edge_move_y", 32'(sy_a[9:0]), 35);
    check("edge_move_mask", 32'(mask_a), 32'h1);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    check("retire_mask", 32'(mask_a), 0);
    check("retire_y_held", 32'(sy_a[9:0]), 35);

    // Retire at y=38
    do_reset();
    tank_y = 10'd44;
    fire_then_tick();
    check("y38_spawn", 32'(sy_a[9:0]), 38);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    check("y38_retire_mask", 32'(mask_a), 0);
    check("y38_no_underflow", 32'(sy_a[9:0]), 38);

    // Zero-cooldown instance: fill, then hit slot 2 on a tick with a fire edge
    do_reset();
    tank_x = 10'd100;
    tank_y = 10'd515;
    repeat (4) fire_then_tick();
    check("fill_mask", 32'(mask_b), 32'hf);
    fire = 1'b1; tick = 1'b1; hit_valid = 1'b1; hit_slot = 2'd2;
    cyc();
    fire = 1'b0; tick = 1'b0; hit_valid = 1'b0;
    check("hit_tick_mask", 32'(mask_b), 32'hb);
    check("hit_tick_drop", 32'(drop_b), 1);
    check("hit_tick_noshot", 32'(shot_b), 0);
    cyc();
    fire_then_tick();
    check("realloc_shot", 32'(shot_b), 1);
    check("realloc_mask", 32'(mask_b), 32'hf);
    check("realloc_x", 32'(sx_b[29:20]), 100);
    check("realloc_y", 32'(sy_b[29:20]), 509);

    // Hit on an inactive slot changes nothing; then reduce to three active
    hCount = 10'd100;
    vCount = 10'd510;
    hit_valid = 1'b1; hit_slot = 2'd3;
    cyc();
    hit_valid = 1'b0;
    check("pixel_before_reset", 32'(pix_b), 1);
    check("three_active", 32'(mask_b), 32'h7);
    hit_valid = 1'b1; hit_slot = 2'd3;
    cyc();
    hit_valid = 1'b0;
    check("inactive_hit_ignored", 32'(mask_b), 32'h7);

    // Asynchronous reset mid-cycle
    #2;
    rst = 1'b0;
    #1;
    check("async_mask", 32'(mask_b), 0);
    check("async_pixel", 32'(pix_b), 0);
    cyc();
    rst = 1'b1;
    cyc();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    check("post_reset_noshot", 32'(shot_b), 0);
    check("post_reset_mask", 32'(mask_b), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bullet_scheduler.md
Name: bullet_scheduler

Overview:
- Owns the player's bullet slot pool and issues shots for the player tank.
- Turns fire-button presses into bullet spawns at the tank position, with a cooldown between shots.
- Advances active bullets upward once per game tick and retires them at the top of the visible area or on a hit report.
- Produces a registered per-pixel "bullet here" flag for the pixel colour mux, plus slot status for the collision logic.

Parameters:
- NUM_SLOTS, 4, number of simultaneous bullets (2..8); slot index width is SW = clog2(NUM_SLOTS).
- SPEED, 4, pixels a bullet moves up per tick.
- COOLDOWN, 8, ticks after a spawn during which new fire requests are dropped.
- TOP_Y, 35, first visible vCount line; a bullet is retired when its next y would fall below this.
- BULLET_H, 6, bullet height in lines.
- BULLET_HW, 1, bullet half-width; drawn width is 2*BULLET_HW+1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- fire  in  1  debounced fire button, level.
- tick  in  1  one-clk game-step strobe.
- tank_x  in  10  tank centre hCount.
- tank_y  in  10  tank top vCount.
- hit_valid  in  1  collision logic reports that slot hit_slot struck a monster.
- hit_slot  in  SW  slot index being reported.
- hCount  in  10  current pixel column.
- vCount  in  10  current pixel row.
- bullet_pixel  out  1  registered: the current pixel is covered by an active bullet.
- active_mask  out  NUM_SLOTS  slot i is in flight.
- slot_x  out  10*NUM_SLOTS  packed per-slot x; slot i occupies bits [10i+9:10i].
- slot_y  out  10*NUM_SLOTS  packed per-slot top y; same packing.
- shot_fired  out  1  one-clk pulse when a slot is allocated.
- fire_dropped  out  1  one-clk pulse when a pending request is discarded.

Behaviour:
- Reset (rst=0, async):
  - active_mask=0; all slot_x and slot_y=0.
  - cooldown=0, pending=0, fire_d=0.
  - bullet_pixel, shot_fired and fire_dropped all 0.
- Edge detect:
  - fire_d <= fire every clk.
  - A rising edge (fire & ~fire_d) sets pending=1.
  - Further edges while pending=1 are absorbed; no queueing beyond one request.
- Hit (any clk):
  - hit_valid=1 clears active_mask[hit_slot] on that clk edge.
  - A hit on an already inactive slot is ignored.
- Tick processing (tick=1), all decisions taken from the pre-edge state (call it mask0):
  - Move: every slot in mask0 that is not hit this clk gets y <= y - SPEED.
  - Retire: if y < TOP_Y + SPEED, the slot is cleared instead of moved. No wrap-around, no 10-bit underflow.
  - Allocate: when pending=1, cooldown=0, at least one slot is free in mask0, and tank_y >= TOP_Y + BULLET_H:
    - lowest-index free slot gets x = tank_x, y = tank_y - BULLET_H, active=1;
    - cooldown <= COOLDOWN; shot_fired=1 for that clk.
  - Drop: otherwise, if pending=1, the request is discarded and fire_dropped=1 for that clk.
  - pending is cleared on every tick where it was set, whether serviced or dropped.
  - A slot freed by retire or hit in the same clk is not reallocatable until the next tick.
  - A newly allocated slot does not move on its spawn tick.
  - Cooldown: when cooldown>0 and no allocation occurs, cooldown decrements by 1. It saturates at 0.
- Edge coincidences:
  - A rising fire edge on the same clk as tick: the edge counts toward that same tick (pending is treated as set).
  - Hit and tick on the same slot in the same clk: the hit wins; the slot is cleared, not moved.
- Pixel output:
  - Registered, 1-clk latency.
  - bullet_pixel <= OR over active slots of (hCount ≥ x-BULLET_HW, hCount ≤ x+BULLET_HW, vCount ≥ y, vCount ≤ y+BULLET_H-1).
  - x-BULLET_HW uses 11-bit compare so x < BULLET_HW does not wrap.
- Reset asserted mid-flight clears all slots immediately; no spawn occurs on the first tick after release unless a new fire edge arrives.

Test Plan:
- Reset, then fire edge, then tick, with tank_x=450, tank_y=515 -> slot0 active at x=450, y=509; shot_fired pulses; cooldown=8.
- After spawn, 3 ticks -> slot0 y=497; bullet_pixel=1 one clk after (hCount,vCount)=(451,500); 0 at (452,500).
- Fire edges before each of 10 consecutive ticks -> spawns on ticks 1 and 10 only; fire_dropped on ticks 2-9.
- Slot at y=38 on tick -> retired; active_mask bit clears; y not decremented below 35.
- Fill all 4 slots using COOLDOWN=0, then hit_valid with hit_slot=2 on the same clk as a tick carrying a pending fire -> slot2 cleared and not reallocated that tick; fire_dropped=1; next fire plus tick allocates slot2.
- Assert rst=0 with 3 slots active mid-frame -> active_mask=0 and bullet_pixel=0 immediately (async).
